// File: rtl/rf2p_fifo_if.sv
`default_nettype none
// ============================================================================
// Module      : rf2p_fifo_if
// Description : Handshake/data bundle for rf2p_fifo.
//               master : producer/consumer side (drives flush/push/wData/pop)
//               slave  : FIFO side (drives rData, rData_vld, status, flags)
//   flush        master->slave  synchronous clear
//   push/wData   master->slave  write request + data
//   pop          master->slave  read request
//   rData        slave->master  registered read data
//   rData_vld    slave->master  rData holds the word popped on previous edge
//   empty/full/almost_full/count  occupancy status
//   ovf/udf      sticky error flags (tied 0 unless RF2P_FIFO_ERR_FLAG_EN)
// Revision    : 1.0  initial release
// ============================================================================
interface rf2p_fifo_if #(
    parameter int L_data  = 27,
    parameter int nb_data = 16
);
    localparam int L_cnt = $clog2(nb_data + 1);

    logic              flush;
    logic              push;
    logic [L_data-1:0] wData;
    logic              pop;
    logic [L_data-1:0] rData;
    logic              rData_vld;
    logic              empty;
    logic              full;
    logic              almost_full;
    logic [L_cnt-1:0]  count;
    logic              ovf;
    logic              udf;

    modport master (
        output flush, push, wData, pop,
        input  rData, rData_vld, empty, full, almost_full, count, ovf, udf
    );

    modport slave (
        input  flush, push, wData, pop,
        output rData, rData_vld, empty, full, almost_full, count, ovf, udf
    );
endinterface
`default_nettype wire

// File: rtl/rf2p_fifo.sv
`default_nettype none
// ============================================================================
// Module      : rf2p_fifo
// Description : Synchronous FIFO on a 2-port register-file array. One write
//               port, one read port, registered read data (1-cycle latency),
//               occupancy count, almost_full, synchronous flush.
// Ports       : clk  - sole clock, rising edge
//               rst  - asynchronous active-high reset
//               bus  - rf2p_fifo_if.slave (push/pop/flush in; data/status out)
// Config      : define RF2P_FIFO_ERR_FLAG_EN to enable sticky ovf/udf flags;
//               otherwise both are tied to 0 (port list unchanged).
// Revision    : 1.0  initial release
// ============================================================================
module rf2p_fifo #(
    parameter int L_data   = 27,
    parameter int nb_data  = 16,
    parameter int AFULL_TH = nb_data - 2
) (
    input  wire logic  clk,
    input  wire logic  rst,
    rf2p_fifo_if.slave bus
);
    localparam int L_addr = $clog2(nb_data);
    localparam int L_cnt  = $clog2(nb_data + 1);

    localparam logic [L_cnt-1:0]  c_DEPTH     = L_cnt'(nb_data);
    localparam logic [L_cnt-1:0]  c_AFULL     = L_cnt'(AFULL_TH);
    localparam logic [L_addr-1:0] c_LAST_ADDR = L_addr'(nb_data - 1);

    logic [L_data-1:0] r_mem [nb_data];
    logic [L_addr-1:0] r_wr_ptr;
    logic [L_addr-1:0] r_rd_ptr;
    logic [L_cnt-1:0]  r_count;
    logic [L_data-1:0] r_rdata;
    logic              r_rdata_vld;

    logic w_empty;
    logic w_full;
    logic w_push_ok;
    logic w_pop_ok;

    // Status flags decode the registered count directly: no extra latency.
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_DEPTH);

    // A push into a full FIFO is still taken when a pop frees a slot on the
    // same edge. Pop on empty is refused, so pushed data is never bypassed.
    assign w_push_ok = bus.push & (~w_full | bus.pop);
    assign w_pop_ok  = bus.pop & ~w_empty;

    // Depth need not be a power of two, so wrap explicitly at nb_data-1.
    function automatic logic [L_addr-1:0] f_next(input logic [L_addr-1:0] p);
        return (p == c_LAST_ADDR) ? '0 : p + L_addr'(1);
    endfunction

    // Storage array: not reset.
    always_ff @(posedge clk) begin
        if (w_push_ok && !bus.flush) begin
            r_mem[r_wr_ptr] <= bus.wData;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_rdata     <= '0;
            r_rdata_vld <= 1'b0;
        end else if (bus.flush) begin
            // rData deliberately holds its last value across a flush.
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_rdata_vld <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= f_next(r_wr_ptr);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= f_next(r_rd_ptr);
                r_rdata  <= r_mem[r_rd_ptr];
            end
            r_rdata_vld <= w_pop_ok;
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + L_cnt'(1);
                2'b01:   r_count <= r_count - L_cnt'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign bus.rData       = r_rdata;
    assign bus.rData_vld   = r_rdata_vld;
    assign bus.empty       = w_empty;
    assign bus.full        = w_full;
    assign bus.almost_full = (r_count >= c_AFULL);
    assign bus.count       = r_count;

`ifdef RF2P_FIFO_ERR_FLAG_EN
    logic r_ovf;
    logic r_udf;

    // Events use the raw requests, so a push dropped on full (no pop) and a
    // pop refused on empty are both recorded; flush masks and clears them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else if (bus.flush) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            if (bus.push && w_full && !bus.pop) begin
                r_ovf <= 1'b1;
            end
            if (bus.pop && w_empty) begin
                r_udf <= 1'b1;
            end
        end
    end

    assign bus.ovf = r_ovf;
    assign bus.udf = r_udf;
`else
    assign bus.ovf = 1'b0;
    assign bus.udf = 1'b0;
`endif

endmodule
`default_nettype wire
